addr_gen_write_phase2: RTL



---
 rtl/addr_gen_write_phase2.sv | 113 +++++++++++
 1 files changed

// File: rtl/addr_gen_write_phase2.sv
// Phase-2 write address generator: walks four destination channel groups and
// issues bursts of at most C_BURST_BYTES until each group's byte count is consumed.
module addr_gen_write_phase2 #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_XFER_SIZE_WIDTH  = 64,
  parameter int unsigned CHANNEL_OFFSET     = 0,
  parameter int unsigned C_BURST_BYTES      = 4096
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          i_start,
  input  logic                          i_pass_parity,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_ptr_ch_0,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  i_xfer_size_in_bytes,
  output logic                          o_req_valid,
  input  logic                          i_req_ready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] o_req_addr,
  output logic [31:0]                   o_req_bytes,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam logic [C_XFER_SIZE_WIDTH-1:0] BURST = C_XFER_SIZE_WIDTH'(C_BURST_BYTES);

  typedef enum logic [1:0] {IDLE, CALC, ISSUE, DONE} state_t;

  state_t                        state, state_nxt;
  logic                          parity_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] ptr_q;
  logic [C_XFER_SIZE_WIDTH-1:0]  size_q;
  logic [C_XFER_SIZE_WIDTH-1:0]  remaining;
  logic [1:0]                    group;
  logic [27:0]                   offset;
  logic [C_M_AXI_ADDR_WIDTH-1:0] ch_num;
  logic [C_M_AXI_ADDR_WIDTH-1:0] ch_base;
  logic                          last_of_group;

  // Destination channel is 2g+1 for parity 0 and 2g for parity 1, i.e. {g, ~parity}.
  always_comb begin
    ch_num        = C_M_AXI_ADDR_WIDTH'({group, ~parity_q}) + C_M_AXI_ADDR_WIDTH'(CHANNEL_OFFSET);
    ch_base       = ptr_q + (ch_num << 28);
    last_of_group = (remaining <= BURST);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_req_valid = 1'b0;
    o_req_addr  = '0;
    o_req_bytes = '0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nxt = CALC;
      end
      CALC: state_nxt = (size_q == '0) ? DONE : ISSUE;
      ISSUE: begin
        o_req_valid = 1'b1;
        // Offset wraps inside the low 28 bits so it never carries into the channel field.
        o_req_addr  = {ch_base[C_M_AXI_ADDR_WIDTH-1:28], ch_base[27:0] + offset};
        o_req_bytes = last_of_group ? 32'(remaining) : 32'(C_BURST_BYTES);
        if (i_req_ready && last_of_group && group == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      parity_q  <= 1'b0;
      ptr_q     <= '0;
      size_q    <= '0;
      remaining <= '0;
      group     <= '0;
      offset    <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          parity_q <= i_pass_parity;
          ptr_q    <= i_ptr_ch_0;
          size_q   <= i_xfer_size_in_bytes;
        end
        CALC: begin
          group     <= '0;
          offset    <= '0;
          remaining <= size_q;
        end
        ISSUE: if (i_req_ready) begin
          if (last_of_group) begin
            group     <= group + 2'd1;
            offset    <= '0;
            remaining <= size_q;
          end else begin
            offset    <= offset + 28'(C_BURST_BYTES);
            remaining <= remaining - BURST;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
